// File: rtl/exibe_sequencia.sv
// Memory game sequence presenter: reads positions 0..limite from game memory and
// flashes each value on the LEDs for TEMPO_LED cycles, followed by a TEMPO_APAGADO blank gap.
module exibe_sequencia #(
    parameter int TEMPO_LED     = 1000,
    parameter int TEMPO_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int TEMPO_MAX = (TEMPO_LED > TEMPO_APAGADO) ? TEMPO_LED : TEMPO_APAGADO;
    localparam int TW        = (TEMPO_MAX > 1) ? $clog2(TEMPO_MAX) : 1;

    typedef enum logic [3:0] {
        st_inicial    = 4'h0,
        st_preparacao = 4'h1,
        st_mostra     = 4'h2,
        st_apagado    = 4'h3,
        st_proximo    = 4'h4,
        st_fim        = 4'hF
    } estado_t;

    estado_t       estado_reg, estado_next;
    logic [3:0]    endereco_reg;
    logic [3:0]    limite_reg;
    logic [TW-1:0] timer_reg;
    logic          fim_led, fim_apagado, ultima_pos;

    assign fim_led     = (timer_reg == TW'(TEMPO_LED - 1));
    assign fim_apagado = (timer_reg == TW'(TEMPO_APAGADO - 1));
    assign ultima_pos  = (endereco_reg == limite_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg <= st_inicial;
        end else begin
            estado_reg <= estado_next;
        end
    end

    // Address, timer and captured limit; the limit is latched only in preparacao.
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco_reg <= 4'd0;
            timer_reg    <= '0;
            limite_reg   <= 4'd0;
        end else begin
            case (estado_reg)
                st_preparacao: begin
                    endereco_reg <= 4'd0;
                    timer_reg    <= '0;
                    limite_reg   <= limite;
                end
                st_mostra:  timer_reg <= fim_led ? '0 : timer_reg + TW'(1);
                st_apagado: timer_reg <= fim_apagado ? '0 : timer_reg + TW'(1);
                st_proximo: endereco_reg <= endereco_reg + 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            st_inicial:    if (iniciar) estado_next = st_preparacao;
            st_preparacao: estado_next = st_mostra;
            st_mostra:     if (fim_led) estado_next = st_apagado;
            st_apagado:    if (fim_apagado) estado_next = ultima_pos ? st_fim : st_proximo;
            st_proximo:    estado_next = st_mostra;
            st_fim:        estado_next = st_inicial;
            default:       estado_next = st_inicial;
        endcase
    end

    always_comb begin
        leds      = 4'b0000;
        exibindo  = 1'b1;
        pronto    = 1'b0;
        db_estado = estado_reg;
        case (estado_reg)
            st_inicial: exibindo = 1'b0;
            st_mostra:  leds = dado;
            st_fim: begin
                exibindo = 1'b0;
                pronto   = 1'b1;
            end
            default: ;
        endcase
    end

    assign endereco = endereco_reg;

endmodule

// File: doc/exibe_sequencia.md
# exibe_sequencia

Sequence presenter for the memory game: the output-side counterpart of the player-input datapath. On command it reads the stored sequence from the game memory, position 0 up to the current round limit, and shows each value on the LEDs for a fixed on-time followed by a blank gap, then pulses `pronto`. It sits beside the data path and is commanded by the game control unit before each round of player input.

## Interface

- `TEMPO_LED`, 1000, cycles each value stays lit (≥1)
- `TEMPO_APAGADO`, 500, cycles of blank gap after each value (≥1)
- `clock`  input  1  system clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high; one clock and synchronous active-high reset, as already decided
- `iniciar`  input  1  start request, sampled only in state `inicial`
- `limite`  input  4  last position to show (0..15), captured at start
- `dado`  input  4  memory read data, combinational (asynchronous-read) function of `endereco`
- `endereco`  output  4  memory read address (registered)
- `leds`  output  4  `dado` while in `mostra`, else 4'b0000
- `exibindo`  output  1  high in every state except `inicial` and `fim`
- `pronto`  output  1  one-cycle pulse in state `fim`
- `db_estado`  output  4  state code, for the hexa7seg debug display

## Operation

- State codes: `inicial`=0, `preparacao`=1, `mostra`=2, `apagado`=3, `proximo`=4, `fim`=F.
- `inicial`: outputs idle. Next state is `preparacao` if `iniciar`=1, else stay.
- `preparacao`, 1 cycle: `endereco`←0, timer←0, `limite_reg`←`limite`. Next state is `mostra`.
- `mostra`: `leds`=`dado` and the timer increments. When timer = `TEMPO_LED`−1, the timer is set to 0 and the next state is `apagado`.
- `apagado`: `leds`=0 and the timer increments. When timer = `TEMPO_APAGADO`−1, the timer is set to 0. Next state is `fim` if `endereco`=`limite_reg`, else `proximo`.
- `proximo`, 1 cycle: `endereco`←`endereco`+1. Next state is `mostra`.
- `fim`, 1 cycle: `pronto`=1. Next state is `inicial`. `endereco` holds its last value.
- Timer width is ⌈log2(max(`TEMPO_LED`,`TEMPO_APAGADO`))⌉ bits, unsigned.
- `endereco` never wraps, because `limite_reg` ≤ 15 stops it before 15+1.
- `iniciar` is ignored outside `inicial`. Holding `iniciar` high through `fim` restarts the sequence from `inicial` on the next edge.
- `limite` changes after `preparacao` are ignored until the next start.
- `reset`=1 on any edge, including mid-sequence: state←`inicial`, `endereco`←0, timer←0, `limite_reg`←0. Reset has priority over `iniciar`.

## Timing

- Reset values: `leds`=0, `endereco`=0, `exibindo`=0, `pronto`=0, `db_estado`=0.
- Let E0 be the edge that samples `iniciar`=1 in `inicial`.
  - `preparacao` occupies the cycle after E0.
  - `mostra` for position 0 starts at E0+1.
- Position p is lit from edge E0+1+p·(`TEMPO_LED`+`TEMPO_APAGADO`+1) for exactly `TEMPO_LED` cycles.
- `fim` is entered at edge E0 + 1 + (L+1)(`TEMPO_LED`+`TEMPO_APAGADO`) + L, where L=`limite_reg`.
- `pronto` is high for exactly one cycle, and `exibindo` is low in that cycle.
- `leds` reflects `dado` in the same cycle, so there is zero latency from a memory change.
- `proximo` adds one extra blank cycle between positions, giving a total gap of `TEMPO_APAGADO`+1.

## Test plan

- **Reset values:** assert `reset` for 2 cycles → all outputs 0 and `db_estado`=0. Holding `iniciar`=1 during reset → stays in `inicial`.
- **Full sequence, L=2:** `TEMPO_LED`=3, `TEMPO_APAGADO`=2, `limite`=2, memory {0:1, 1:2, 2:4}, pulse `iniciar`.
  - `leds` shows 1,2,4, each for 3 cycles.
  - `leds` lit from E0+1, E0+7 and E0+13.
  - `pronto` pulses once at E0+18. `endereco` ends at 2.
- **Single position, L=0:** `limite`=0, same parameters → a single 3-cycle flash, then `pronto` at E0+6 and `endereco` stays 0.
- **Maximum length, L=15:** `limite`=15, memory value = address → 16 flashes showing 0..F, `endereco` reaches F with no wrap, `pronto` at E0+1+16·5+15=E0+96.
- **Reset mid-operation:** assert `reset` during the `mostra` of position 1 → on the next edge `leds`=0, `endereco`=0, `exibindo`=0 and no `pronto` is produced. A new `iniciar` restarts from position 0.
- **Ignored inputs:** pulse `iniciar` and change `limite` from 2 to 5 while in `apagado` → the sequence still stops after position 2 with a single `pronto`.
